// File: rtl/dbio_mailbox.sv
// Dbio target holding a shared 64-bit mailbox with auto-increment burst access,
// a local CPU port with collision reporting, and the debug attention request.
module dbio_mailbox #(
  parameter int          CWordCnt  = 16,
  parameter int          CIdxBits  = 4,
  parameter logic [11:0] CAddrBase = 12'h100
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic [11:0]         ADbioAddr,
  input  logic [63:0]         ADbioMosi,
  input  logic [3:0]          ADbioMosiIdx,
  input  logic [3:0]          ADbioMisoIdx,
  input  logic                ADbioMosi1st,
  input  logic                ADbioMiso1st,
  input  logic                ADbioDataLenNZ,
  output logic [63:0]         ADbioMiso,
  output logic                ADbioIdxReset,
  input  logic [CIdxBits-1:0] ALocIdx,
  input  logic [63:0]         ALocWrData,
  input  logic                ALocWrEn,
  output logic [63:0]         ALocRdData,
  output logic                ALocWrColl,
  output logic                ADbgAttReq,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam logic [CIdxBits-1:0] LAST_IDX = CIdxBits'(CWordCnt - 1);

  logic [63:0]         mem [CWordCnt];
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CIdxBits-1:0] ptr;
  logic                hit;
  logic [3:0]          mosi_idx_prev;

  logic                win_hit;
  logic                hit_eff;
  logic                byte_arrive;
  logic                start;
  logic                rd_start;
  logic                wr_full;
  logic                wr_part;
  logic                rd_reload;
  logic                dbio_we;
  logic                loc_coll;
  logic                att_set;
  logic                att_clr;
  logic [CIdxBits-1:0] addr_idx;

  assign addr_idx    = ADbioAddr[CIdxBits-1:0];
  assign win_hit     = (ADbioAddr[11:CIdxBits] == CAddrBase[11:CIdxBits]);
  assign byte_arrive = (ADbioMosiIdx != mosi_idx_prev);
  assign start       = ADbioMosi1st | ADbioMiso1st;
  assign rd_start    = ADbioMiso1st & ~ADbioMosi1st;

  // Burst actions only apply in the established state, never on a restart cycle.
  assign wr_full   = (state == ST_WR) && !start && (ADbioMosiIdx == 4'd8);
  assign wr_part   = (state == ST_WR) && !start && byte_arrive && !ADbioDataLenNZ &&
                     (ADbioMosiIdx != 4'd0) && (ADbioMosiIdx < 4'd8);
  assign rd_reload = (state == ST_RD) && !start && (ADbioMisoIdx == 4'd8) && ADbioDataLenNZ;

  // IdxReset tells the bridge to clear its byte index and resample ADbioMiso in the same cycle.
  assign ADbioIdxReset = !AResetH && AClkHEn && (wr_full || rd_reload);

  assign dbio_we  = hit && (wr_full || wr_part);
  assign loc_coll = ALocWrEn && dbio_we && (ALocIdx == ptr);
  assign att_set  = ALocWrEn && (ALocIdx == LAST_IDX);
  assign att_clr  = (rd_start && win_hit && (addr_idx == LAST_IDX)) ||
                    (rd_reload && hit && (ptr == LAST_IDX));

  assign hit_eff    = ADbioMiso1st ? win_hit : hit;
  assign ADbioMiso  = !hit_eff ? 64'd0 : (ADbioMiso1st ? mem[addr_idx] : mem[ptr]);
  assign ALocRdData = mem[ALocIdx];
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    if (ADbioMosi1st) begin
      state_nxt = ADbioDataLenNZ ? ST_WR : ST_IDLE;
    end else if (ADbioMiso1st) begin
      state_nxt = ST_RD;
    end else begin
      case (state)
        ST_WR:   if (!ADbioDataLenNZ && byte_arrive) state_nxt = ST_IDLE;
        ST_RD:   if (!ADbioDataLenNZ) state_nxt = ST_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      hit           <= 1'b0;
      mosi_idx_prev <= 4'd0;
      ALocWrColl    <= 1'b0;
      ADbgAttReq    <= 1'b0;
      for (int i = 0; i < CWordCnt; i++) mem[i] <= 64'd0;
    end else if (AClkHEn) begin
      state         <= state_nxt;
      mosi_idx_prev <= ADbioMosiIdx;
      ALocWrColl    <= loc_coll;

      if (start) hit <= win_hit;

      if (ADbioMosi1st)               ptr <= addr_idx;
      else if (ADbioMiso1st)          ptr <= addr_idx + CIdxBits'(1);
      else if (wr_full || rd_reload)  ptr <= ptr + CIdxBits'(1);

      if (att_set)      ADbgAttReq <= 1'b1;
      else if (att_clr) ADbgAttReq <= 1'b0;

      // A local write to the word being committed by Dbio is dropped.
      if (ALocWrEn && !loc_coll) mem[ALocIdx] <= ALocWrData;
      if (dbio_we) begin
        for (int k = 0; k < 8; k++) begin
          if (wr_full || (4'(k) < ADbioMosiIdx)) mem[ptr][8*k +: 8] <= ADbioMosi[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbio_mailbox.sv
// Directed bench for dbio_mailbox: models the bridge side of Dbio bursts
// and checks words, IdxReset pulses, local port, attention and reset.
module tb_dbio_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [11:0] dbio_addr;
  logic [63:0] dbio_mosi;
  logic [3:0]  dbio_mosi_idx;
  logic [3:0]  dbio_miso_idx;
  logic        dbio_mosi_1st;
  logic        dbio_miso_1st;
  logic        dbio_len_nz;
  logic [63:0] dbio_miso;
  logic        dbio_idx_reset;
  logic [3:0]  loc_idx;
  logic [63:0] loc_wr_data;
  logic        loc_wr_en;
  logic [63:0] loc_rd_data;
  logic        loc_wr_coll;
  logic        att_req;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0]  wr_bytes [16];
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];

  bit          coll_en;
  logic [3:0]  coll_idx;
  logic [63:0] coll_data;
  logic [63:0] coll_exp;

  dbio_mailbox dut (
    .AClkH          (clk),
    .AResetH        (rst),
    .AClkHEn        (clk_en),
    .ADbioAddr      (dbio_addr),
    .ADbioMosi      (dbio_mosi),
    .ADbioMosiIdx   (dbio_mosi_idx),
    .ADbioMisoIdx   (dbio_miso_idx),
    .ADbioMosi1st   (dbio_mosi_1st),
    .ADbioMiso1st   (dbio_miso_1st),
    .ADbioDataLenNZ (dbio_len_nz),
    .ADbioMiso      (dbio_miso),
    .ADbioIdxReset  (dbio_idx_reset),
    .ALocIdx        (loc_idx),
    .ALocWrData     (loc_wr_data),
    .ALocWrEn       (loc_wr_en),
    .ALocRdData     (loc_rd_data),
    .ALocWrColl     (loc_wr_coll),
    .ADbgAttReq     (att_req),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dbio_addr     = 12'h000;
    dbio_mosi     = 64'd0;
    dbio_mosi_idx = 4'd0;
    dbio_miso_idx = 4'd0;
    dbio_mosi_1st = 1'b0;
    dbio_miso_1st = 1'b0;
    dbio_len_nz   = 1'b0;
    loc_wr_en     = 1'b0;
    loc_wr_data   = 64'd0;
  endtask

  task automatic loc_write(input logic [3:0] idx, input logic [63:0] data);
    loc_idx     = idx;
    loc_wr_data = data;
    loc_wr_en   = 1'b1;
    tick();
    loc_wr_en   = 1'b0;
  endtask

  task automatic mem_check(input string tag, input logic [3:0] idx, input logic [63:0] exp);
    loc_idx = idx;
    #1;
    check(tag, loc_rd_data, exp);
  endtask

  // driver: write burst of n bytes from wr_bytes, bridge-style
  task automatic dbio_write(input logic [11:0] addr, input int n);
    int idx;
    int rem;
    idx = 0;
    rem = n;
    dbio_addr     = addr;
    dbio_mosi     = 64'd0;
    dbio_mosi_idx = 4'd0;
    dbio_len_nz   = (n != 0);
    dbio_mosi_1st = 1'b1;
    #1;
    check("wr_start_idxrst", 64'(dbio_idx_reset), 64'd0);
    tick();
    dbio_mosi_1st = 1'b0;
    for (int i = 0; i < n; i++) begin
      dbio_mosi[8*idx +: 8] = wr_bytes[i];
      idx++;
      rem--;
      dbio_mosi_idx = 4'(idx);
      dbio_len_nz   = (rem != 0);
      if (idx == 8 && coll_en) begin
        loc_idx     = coll_idx;
        loc_wr_data = coll_data;
        loc_wr_en   = 1'b1;
      end
      #1;
      check("wr_idxrst", 64'(dbio_idx_reset), (idx == 8) ? 64'd1 : 64'd0);
      tick();
      if (idx == 8) begin
        if (coll_en) begin
          check("wr_coll", 64'(loc_wr_coll), coll_exp);
          loc_wr_en = 1'b0;
          coll_en   = 1'b0;
        end
        idx           = 0;
        dbio_mosi     = 64'd0;
        dbio_mosi_idx = 4'd0;
      end
    end
    dbio_mosi_idx = 4'd0;
    dbio_len_nz   = 1'b0;
    tick();
    check("wr_end_idle", 64'(dbg_state), 64'd0);
  endtask

  // driver: read burst of n bytes; sampled words go to got_q
  task automatic dbio_read(input logic [11:0] addr, input int n);
    int idx;
    int rem;
    bit exp_rst;
    idx = 0;
    rem = n;
    dbio_addr     = addr;
    dbio_miso_idx = 4'd0;
    dbio_len_nz   = 1'b1;
    dbio_miso_1st = 1'b1;
    #1;
    got_q.push_back(dbio_miso);
    check("rd_start_idxrst", 64'(dbio_idx_reset), 64'd0);
    tick();
    dbio_miso_1st = 1'b0;
    while (rem > 0) begin
      idx++;
      rem--;
      dbio_miso_idx = 4'(idx);
      dbio_len_nz   = (rem != 0);
      exp_rst       = (idx == 8) && (rem != 0);
      #1;
      check("rd_idxrst", 64'(dbio_idx_reset), exp_rst ? 64'd1 : 64'd0);
      if (exp_rst) got_q.push_back(dbio_miso);
      tick();
      if (idx == 8) idx = 0;
    end
    dbio_miso_idx = 4'd0;
    dbio_len_nz   = 1'b0;
    tick();
    check("rd_end_idle", 64'(dbg_state), 64'd0);
  endtask

  // scoreboard: drain sampled words against expectations
  task automatic score_reads(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check(tag, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    idle_inputs();
    coll_en   = 1'b0;
    coll_idx  = 4'd0;
    coll_data = 64'd0;
    coll_exp  = 64'd0;
    loc_idx   = 4'd0;
    clk_en    = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    check("rst_idxrst", 64'(dbio_idx_reset), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_att", 64'(att_req), 64'd0);
    check("rst_coll", 64'(loc_wr_coll), 64'd0);
    check("rst_miso", dbio_miso, 64'd0);
    mem_check("rst_mem0", 4'd0, 64'd0);
    mem_check("rst_mem15", 4'd15, 64'd0);

    // 1: full word write at 0x103
    for (int i = 0; i < 8; i++) wr_bytes[i] = 8'(8'h11 * (i + 1));
    dbio_write(12'h103, 8);
    mem_check("t1_mem3", 4'd3, 64'h8877665544332211);
    mem_check("t1_mem4", 4'd4, 64'd0);

    // 2: 11 bytes at 0x10F wrap into partial word 0
    loc_write(4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 11; i++) wr_bytes[i] = 8'(8'hA0 + i);
    dbio_write(12'h10F, 11);
    mem_check("t2_mem15", 4'd15, 64'hA7A6A5A4A3A2A1A0);
    mem_check("t2_mem0", 4'd0, 64'hFFFF_FFFF_FFAA_A9A8);
    check("t2_att", 64'(att_req), 64'd0);

    // 3: read 16 bytes at 0x102
    loc_write(4'd2, 64'h0123456789ABCDEF);
    loc_write(4'd3, 64'hFEDCBA9876543210);
    exp_q.push_back(64'h0123456789ABCDEF);
    exp_q.push_back(64'hFEDCBA9876543210);
    dbio_read(12'h102, 16);
    score_reads("t3_rd");

    // 4: out-of-window write and read
    for (int i = 0; i < 8; i++) wr_bytes[i] = 8'(8'h11 * (i + 1));
    dbio_write(12'h200, 8);
    mem_check("t4_mem0", 4'd0, 64'hFFFF_FFFF_FFAA_A9A8);
    mem_check("t4_mem1", 4'd1, 64'd0);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    dbio_read(12'h200, 16);
    score_reads("t4_rd");

    // 5: attention set by local write, cleared by Dbio read of word 15
    loc_idx     = 4'd15;
    loc_wr_data = 64'h5A5A_0000_1234_5678;
    loc_wr_en   = 1'b1;
    #1;
    check("t5_att_before", 64'(att_req), 64'd0);
    tick();
    loc_wr_en = 1'b0;
    check("t5_att_set", 64'(att_req), 64'd1);
    exp_q.push_back(64'h5A5A_0000_1234_5678);
    dbio_read(12'h10F, 8);
    score_reads("t5_rd");
    check("t5_att_clr", 64'(att_req), 64'd0);

    // 5b: same-index collision, Dbio wins
    coll_en   = 1'b1;
    coll_idx  = 4'd5;
    coll_data = 64'hDEAD_BEEF_DEAD_BEEF;
    coll_exp  = 64'd1;
    dbio_write(12'h105, 8);
    check("t5_coll_after", 64'(loc_wr_coll), 64'd0);
    mem_check("t5_mem5", 4'd5, 64'h8877665544332211);

    // 5c: different-index simultaneous writes both land
    coll_en   = 1'b1;
    coll_idx  = 4'd6;
    coll_data = 64'hCAFE_F00D_CAFE_F00D;
    coll_exp  = 64'd0;
    dbio_write(12'h107, 8);
    mem_check("t5_mem6", 4'd6, 64'hCAFE_F00D_CAFE_F00D);
    mem_check("t5_mem7", 4'd7, 64'h8877665544332211);

    // 6: reset mid-burst
    loc_write(4'd15, 64'h1);
    check("t6_att_set", 64'(att_req), 64'd1);
    dbio_addr     = 12'h101;
    dbio_len_nz   = 1'b1;
    dbio_mosi_1st = 1'b1;
    tick();
    dbio_mosi_1st = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      dbio_mosi[8*(i-1) +: 8] = 8'(8'h30 + i);
      dbio_mosi_idx = 4'(i);
      tick();
    end
    check("t6_state_wr", 64'(dbg_state), 64'd1);
    rst           = 1'b1;
    dbio_mosi_idx = 4'd8;
    #1;
    check("t6_rst_idxrst", 64'(dbio_idx_reset), 64'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("t6_state", 64'(dbg_state), 64'd0);
    check("t6_att", 64'(att_req), 64'd0);
    check("t6_idxrst", 64'(dbio_idx_reset), 64'd0);
    for (int i = 0; i < 16; i++) mem_check("t6_mem", 4'(i), 64'd0);

    // clock enable low: local write must not land
    clk_en = 1'b0;
    loc_write(4'd4, 64'h4444);
    mem_check("en_hold", 4'd4, 64'd0);
    clk_en = 1'b1;
    loc_write(4'd4, 64'h4444);
    mem_check("en_write", 4'd4, 64'h4444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got=stalled expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
